axi_mem_slave: RTL and testbench

AXI4 responder (slave) backed by an on-chip word array, serving the single-ID, 32-bit AXI master that the packet processor uses for table and counter memory. It sits at the far end of that master's AXI bus and serves as the processor's simulation and FPGA memory model. It processes one transaction at a time, supports INCR and FIXED bursts up to 256 beats, applies byte strobes, and arbitrates AW against AR round-robin.

---
 rtl/axi_mem_slave.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_slave.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | axi_mem_slave: single-outstanding AXI4 responder backed by a word array.   |
// | Optional beat/size error responses under `AXI_MEM_SLV_ERR_EN.             |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module axi_mem_slave #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  axi_awid,
  input  logic [31:0] axi_awaddr,
  input  logic [7:0]  axi_awlen,
  input  logic [2:0]  axi_awsize,
  input  logic [1:0]  axi_awburst,
  input  logic        axi_awlock,
  input  logic [3:0]  axi_awcache,
  input  logic [2:0]  axi_awprot,
  input  logic [3:0]  axi_awqos,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wlast,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bid,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  input  logic [1:0]  axi_arid,
  input  logic [31:0] axi_araddr,
  input  logic [7:0]  axi_arlen,
  input  logic [2:0]  axi_arsize,
  input  logic [1:0]  axi_arburst,
  input  logic        axi_arlock,
  input  logic [3:0]  axi_arcache,
  input  logic [2:0]  axi_arprot,
  input  logic [3:0]  axi_arqos,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [1:0]  axi_rid,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rlast,
  output logic        axi_rvalid,
  input  logic        axi_rready
);

  localparam int c_depth = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_wr_prio;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic [1:0]  r_burst;
  logic        r_size_err;
  logic        r_err;
  logic        r_wready;
  logic        r_bvalid;
  logic [1:0]  r_bid;
  logic [1:0]  r_bresp;
  logic        r_rvalid;
  logic        r_rlast;
  logic [1:0]  r_rid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [c_depth];

  logic [31:0]           w_next_addr;
  logic [31:0]           w_rd_addr;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic [DEPTH_LOG2-1:0] w_wr_idx;
  logic [31:0]           w_rd_word;
  logic                  w_rd_err;
  logic                  w_wr_err;
  logic                  w_mem_we;
  logic                  w_unused;

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] addr);
    return DEPTH_LOG2'((addr - BASE_ADDR) >> 2);
  endfunction

  // FIXED holds the address; INCR, WRAP and reserved all step by one word.
  assign w_next_addr = (r_burst == 2'b00) ? r_addr : r_addr + 32'd4;
  assign w_rd_addr   = (r_state == IDLE) ? axi_araddr : w_next_addr;
  assign w_rd_idx    = word_idx(w_rd_addr);
  assign w_wr_idx    = word_idx(r_addr);
  assign w_rd_word   = r_mem[w_rd_idx];

`ifdef AXI_MEM_SLV_ERR_EN
  logic w_rd_size_err;

  function automatic logic addr_err(input logic [31:0] addr);
    logic [32:0] diff;
    diff = {1'b0, addr} - {1'b0, BASE_ADDR};
    return diff[32] | (diff[31:2] >= 30'(c_depth));
  endfunction

  assign w_rd_size_err = (r_state == IDLE) ? (axi_arsize != 3'b010) : r_size_err;
  assign w_rd_err      = w_rd_size_err | addr_err(w_rd_addr);
  assign w_wr_err      = r_size_err | addr_err(r_addr);
`else
  assign w_rd_err = 1'b0;
  assign w_wr_err = 1'b0;
`endif

  assign w_unused = ^{axi_awlock, axi_awcache, axi_awprot, axi_awqos, axi_wlast,
                      axi_arlock, axi_arcache, axi_arprot, axi_arqos, r_size_err};

  // Round-robin: whichever channel was not served last wins a tie.
  assign axi_awready = (r_state == IDLE) & (~axi_arvalid | r_wr_prio);
  assign axi_arready = (r_state == IDLE) & (~axi_awvalid | ~r_wr_prio);

  assign axi_wready = r_wready;
  assign axi_bvalid = r_bvalid;
  assign axi_bid    = r_bid;
  assign axi_bresp  = r_bresp;
  assign axi_rvalid = r_rvalid;
  assign axi_rlast  = r_rlast;
  assign axi_rid    = r_rid;
  assign axi_rresp  = r_rresp;
  assign axi_rdata  = r_rdata;

  assign w_mem_we = (r_state == WR_DATA) & axi_wvalid & ~w_wr_err;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (axi_wstrb[i]) r_mem[w_wr_idx][8*i +: 8] <= axi_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_wr_prio  <= 1'b1;
      r_addr     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_burst    <= '0;
      r_size_err <= 1'b0;
      r_err      <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bid      <= '0;
      r_bresp    <= '0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rid      <= '0;
      r_rresp    <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (axi_awvalid && axi_awready) begin
            r_bid      <= axi_awid;
            r_addr     <= axi_awaddr;
            r_len      <= axi_awlen;
            r_burst    <= axi_awburst;
            r_size_err <= (axi_awsize != 3'b010);
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_wready   <= 1'b1;
            r_wr_prio  <= 1'b0;
            r_state    <= WR_DATA;
          end else if (axi_arvalid && axi_arready) begin
            r_rid      <= axi_arid;
            r_addr     <= axi_araddr;
            r_len      <= axi_arlen;
            r_burst    <= axi_arburst;
            r_size_err <= (axi_arsize != 3'b010);
            r_cnt      <= '0;
            r_rvalid   <= 1'b1;
            r_rlast    <= (axi_arlen == 8'd0);
            r_rdata    <= w_rd_err ? 32'd0 : w_rd_word;
            r_rresp    <= w_rd_err ? 2'b10 : 2'b00;
            r_wr_prio  <= 1'b1;
            r_state    <= RD_DATA;
          end
        end
        WR_DATA: begin
          if (axi_wvalid) begin
            if (w_wr_err) r_err <= 1'b1;
            r_addr <= w_next_addr;
            r_cnt  <= r_cnt + 8'd1;
            // Beat count alone ends the burst; wlast is advisory.
            if (r_cnt == r_len) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_err | w_wr_err) ? 2'b10 : 2'b00;
              r_state  <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (axi_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        RD_DATA: begin
          if (axi_rready) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_state  <= IDLE;
            end else begin
              r_addr  <= w_next_addr;
              r_cnt   <= r_cnt + 8'd1;
              r_rlast <= ((r_cnt + 8'd1) == r_len);
              r_rdata <= w_rd_err ? 32'd0 : w_rd_word;
              r_rresp <= w_rd_err ? 2'b10 : 2'b00;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_axi_mem_slave: randomized scoreboard bench against a word-array model.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_axi_mem_slave;
  localparam int          DL   = 4;
  localparam int          DEP  = 1 << DL;
  localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef AXI_MEM_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [1:0] axi_awid, axi_arid, axi_bid, axi_rid, axi_bresp, axi_rresp;
  logic [1:0] axi_awburst, axi_arburst;
  logic [31:0] axi_awaddr, axi_araddr, axi_wdata, axi_rdata;
  logic [7:0] axi_awlen, axi_arlen;
  logic [2:0] axi_awsize, axi_arsize;
  logic [3:0] axi_wstrb;
  logic axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic axi_rlast, axi_rvalid, axi_rready;

  always #5 clk = ~clk;

  axi_mem_slave #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(1'b0),
    .axi_awcache(4'h0), .axi_awprot(3'h0), .axi_awqos(4'h0),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(1'b0),
    .axi_arcache(4'h0), .axi_arprot(3'h0), .axi_arqos(4'h0),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  typedef struct { logic [1:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
  typedef struct { logic [1:0] id; logic [1:0] resp; } bresp_t;

  rbeat_t      exp_r[$];
  bresp_t      exp_b[$];
  logic [31:0] model_mem [DEP];
  int          vectors = 0;
  int          miscompares = 0;
  logic        hs_other;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  function automatic int midx(input logic [31:0] a);
    logic [31:0] w;
    w = (a - BASE) >> 2;
    return int'(w % DEP);
  endfunction

  function automatic bit merr(input logic [31:0] a, input logic [2:0] size);
    bit oor;
    oor = (a < BASE) || (((a - BASE) >> 2) >= DEP);
    return ERR_EN && (oor || size != 3'd2);
  endfunction

  function automatic logic sig(input int ch);
    case (ch)
      0: return axi_awready;
      1: return axi_wready;
      2: return axi_arready;
      3: return axi_bvalid;
      default: return axi_rvalid;
    endcase
  endfunction

  // Called just after a rising edge; returns at a falling edge with the signal high.
  task automatic wait_sig(input int ch, input string name);
    int n = 0;
    @(negedge clk);
    while (!sig(ch)) begin
      n++;
      if (n > 300) begin
        vectors++;
        miscompares++;
        $display("FAIL timeout_%s: got 0 for 300 cycles, required 1", name);
        finish_run();
      end
      @(negedge clk);
    end
  endtask

  function automatic logic pick(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 2) return (k % 2 == 0);
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic aw_issue(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
    axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awburst = burst; axi_awsize = size;
    axi_awvalid = 1'b1;
    wait_sig(0, "awready");
    hs_other = axi_arready & axi_arvalid;
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size,
                          input logic [31:0] data[$], input logic [3:0] strb[$],
                          input bit gaps, input int bdelay);
    bit err = 1'b0;
    logic [31:0] a = addr;
    aw_issue(id, addr, len, burst, size);
    for (int b = 0; b <= int'(len); b++) begin
      if (b > 0 && gaps && $urandom_range(0, 3) == 0) begin
        axi_wvalid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      axi_wdata = data[b]; axi_wstrb = strb[b]; axi_wlast = (b == int'(len)); axi_wvalid = 1'b1;
      if (merr(a, size)) err = 1'b1;
      else for (int i = 0; i < 4; i++)
        if (strb[b][i]) model_mem[midx(a)][8*i +: 8] = data[b][8*i +: 8];
      if (burst != 2'b00) a = a + 32'd4;
      if (b == 0) begin
        @(negedge clk);
        check("wready_after_aw", axi_wready, 1'b1);
        if (!axi_wready) wait_sig(1, "wready");
      end else begin
        wait_sig(1, "wready");
      end
      @(posedge clk); #1;
    end
    axi_wvalid = 1'b0; axi_wlast = 1'b0;
    exp_b.push_back('{id, err ? 2'b10 : 2'b00});
    if (bdelay == 0) axi_bready = 1'b1;
    @(negedge clk);
    check("bvalid_after_last_w", axi_bvalid, 1'b1);
    if (bdelay > 0) begin
      repeat (bdelay) @(posedge clk);
      #1;
      axi_bready = 1'b1;
      wait_sig(3, "bvalid");
    end else if (!axi_bvalid) begin
      wait_sig(3, "bvalid");
    end
    @(posedge clk); #1;
    axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size, input int mode);
    logic [31:0] a = addr;
    bit last_hs = 1'b0;
    int k;
    axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arburst = burst; axi_arsize = size;
    axi_arvalid = 1'b1;
    wait_sig(2, "arready");
    hs_other = axi_awready & axi_awvalid;
    for (int b = 0; b <= int'(len); b++) begin
      if (merr(a, size)) exp_r.push_back('{id, 32'd0, 2'b10, b == int'(len)});
      else exp_r.push_back('{id, model_mem[midx(a)], 2'b00, b == int'(len)});
      if (burst != 2'b00) a = a + 32'd4;
    end
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    axi_rready = pick(mode, 0);
    k = 1;
    @(negedge clk);
    check("rvalid_after_ar", axi_rvalid, 1'b1);
    while (!last_hs) begin
      last_hs = axi_rvalid & axi_rready & axi_rlast;
      @(posedge clk); #1;
      if (!last_hs) begin
        if (k > 3000) begin
          vectors++;
          miscompares++;
          $display("FAIL timeout_rlast: got no last beat in 3000 cycles, required one");
          finish_run();
        end
        axi_rready = pick(mode, k);
        k++;
        @(negedge clk);
      end
    end
    axi_rready = 1'b0;
  endtask

  // Scoreboard monitor plus hold-while-stalled checks.
  logic        hold_r = 1'b0, hold_b = 1'b0, h_rlast, mon_stop = 1'b0;
  logic [31:0] h_rdata;
  logic [1:0]  h_rid, h_rresp, h_bid, h_bresp;
  rbeat_t      er;
  bresp_t      eb;

  always @(negedge clk) begin
    if (!rst || mon_stop) begin
      hold_r = 1'b0;
      hold_b = 1'b0;
    end else begin
      if (hold_r) begin
        check("rvalid_hold", axi_rvalid, 1'b1);
        check("rdata_hold", axi_rdata, h_rdata);
        check("rlast_hold", axi_rlast, h_rlast);
        check("rid_hold", axi_rid, h_rid);
        check("rresp_hold", axi_rresp, h_rresp);
      end
      if (hold_b) begin
        check("bvalid_hold", axi_bvalid, 1'b1);
        check("bid_hold", axi_bid, h_bid);
        check("bresp_hold", axi_bresp, h_bresp);
      end
      if (axi_rvalid && axi_rready) begin
        if (exp_r.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL r_unexpected: got beat 0x%0h, required none", axi_rdata);
        end else begin
          er = exp_r.pop_front();
          check("rid", axi_rid, er.id);
          check("rdata", axi_rdata, er.data);
          check("rresp", axi_rresp, er.resp);
          check("rlast", axi_rlast, er.last);
        end
      end
      if (axi_bvalid && axi_bready) begin
        if (exp_b.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL b_unexpected: got bid %0d, required none", axi_bid);
        end else begin
          eb = exp_b.pop_front();
          check("bid", axi_bid, eb.id);
          check("bresp", axi_bresp, eb.resp);
        end
      end
      hold_r = axi_rvalid & ~axi_rready;
      h_rdata = axi_rdata; h_rlast = axi_rlast; h_rid = axi_rid; h_rresp = axi_rresp;
      hold_b = axi_bvalid & ~axi_bready;
      h_bid = axi_bid; h_bresp = axi_bresp;
    end
  end

  logic [31:0] dq[$];
  logic [3:0]  sq[$];
  logic [1:0]  t_id, t_burst;
  logic [31:0] t_addr;
  logic [7:0]  t_len;
  logic [2:0]  t_size;

  initial begin
    rst = 1'b0;
    axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = 3'd2; axi_awburst = 2'b01;
    axi_awvalid = 1'b0; axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
    axi_bready = 1'b0; axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arsize = 3'd2;
    axi_arburst = 2'b01; axi_arvalid = 1'b0; axi_rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", axi_awready, 1'b1);
    check("rst_arready", axi_arready, 1'b1);
    check("rst_wready", axi_wready, 1'b0);
    check("rst_bvalid", axi_bvalid, 1'b0);
    check("rst_rvalid", axi_rvalid, 1'b0);
    check("rst_rlast", axi_rlast, 1'b0);
    check("rst_bid_bresp", {axi_bid, axi_bresp}, 4'h0);
    check("rst_rid_rresp", {axi_rid, axi_rresp}, 4'h0);
    check("rst_rdata", axi_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Both address channels valid from reset: write, read, write, then the pending read.
    axi_arid = 2'd2; axi_araddr = 32'h20; axi_arlen = 8'd0; axi_arburst = 2'b01; axi_arsize = 3'd2;
    axi_arvalid = 1'b1;
    dq = '{32'hCAFE0001}; sq = '{4'hF};
    do_write(2'd1, 32'h20, 8'd0, 2'b01, 3'd2, dq, sq, 1'b0, 0);
    check("arb1_read_not_taken", hs_other, 1'b0);
    axi_awid = 2'd1; axi_awaddr = 32'h24; axi_awlen = 8'd0; axi_awburst = 2'b01; axi_awsize = 3'd2;
    axi_awvalid = 1'b1;
    do_read(2'd2, 32'h20, 8'd0, 2'b01, 3'd2, 0);
    check("arb2_write_not_taken", hs_other, 1'b0);
    axi_arid = 2'd0; axi_araddr = 32'h24; axi_arvalid = 1'b1;
    dq = '{32'hCAFE0002};
    do_write(2'd1, 32'h24, 8'd0, 2'b01, 3'd2, dq, sq, 1'b0, 0);
    check("arb3_read_not_taken", hs_other, 1'b0);
    do_read(2'd0, 32'h24, 8'd0, 2'b01, 3'd2, 0);

    // Fill every word so later reads are fully defined.
    dq.delete(); sq.delete();
    for (int b = 0; b < DEP; b++) begin dq.push_back($urandom); sq.push_back(4'hF); end
    do_write(2'd0, 32'h0, 8'(DEP - 1), 2'b01, 3'd2, dq, sq, 1'b0, 0);

    dq = '{32'hDEADBEEF}; sq = '{4'hF};
    do_write(2'd1, 32'h10, 8'd0, 2'b01, 3'd2, dq, sq, 1'b0, 1);
    do_read(2'd3, 32'h10, 8'd0, 2'b01, 3'd2, 0);

    dq = '{32'hAABBCCDD};
    do_write(2'd2, 32'h14, 8'd0, 2'b01, 3'd2, dq, sq, 1'b0, 0);
    dq = '{32'h11223344}; sq = '{4'b0101};
    do_write(2'd2, 32'h14, 8'd0, 2'b01, 3'd2, dq, sq, 1'b0, 2);
    do_read(2'd1, 32'h14, 8'd0, 2'b01, 3'd2, 0);

    dq = '{32'd1, 32'd2, 32'd3, 32'd4}; sq = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(2'd3, 32'h100, 8'd3, 2'b01, 3'd2, dq, sq, 1'b0, 0);
    do_read(2'd0, 32'h104, 8'd1, 2'b00, 3'd2, 0);

    dq = '{32'h55AA55AA}; sq = '{4'hF};
    do_write(2'd0, 32'h40, 8'd0, 2'b01, 3'd2, dq, sq, 1'b0, 0);
    do_read(2'd2, 32'h0, 8'd0, 2'b01, 3'd2, 0);

    do_read(2'd1, 32'h8, 8'd2, 2'b01, 3'd2, 2);
    do_read(2'd3, 32'h0, 8'd255, 2'b01, 3'd2, 0);

    // Reset in the middle of a read burst.
    axi_arid = 2'd1; axi_araddr = 32'h0; axi_arlen = 8'd2; axi_arburst = 2'b01; axi_arsize = 3'd2;
    axi_arvalid = 1'b1;
    wait_sig(2, "arready");
    for (int b = 0; b < 3; b++)
      exp_r.push_back('{2'd1, model_mem[midx(32'h0 + 32'(4 * b))], 2'b00, b == 2});
    @(posedge clk); #1;
    axi_arvalid = 1'b0; axi_rready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rvalid_after_reset", axi_rvalid, 1'b0);
    check("rlast_after_reset", axi_rlast, 1'b0);
    check("awready_after_reset", axi_awready, 1'b1);
    exp_r.delete();
    axi_rready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    for (int t = 0; t < 40; t++) begin
      t_id    = 2'($urandom);
      t_addr  = $urandom_range(0, 32'h5F);
      t_len   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 5));
      t_burst = 2'($urandom);
      t_size  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd2;
      if ($urandom_range(0, 1) == 0) begin
        dq.delete(); sq.delete();
        for (int b = 0; b <= int'(t_len); b++) begin dq.push_back($urandom); sq.push_back(4'($urandom)); end
        do_write(t_id, t_addr, t_len, t_burst, t_size, dq, sq, 1'b1, $urandom_range(0, 2));
      end else begin
        do_read(t_id, t_addr, t_len, t_burst, t_size, 1);
      end
    end

    repeat (2) @(posedge clk);
    #1;
    mon_stop = 1'b1;
    check("r_queue_drained", exp_r.size(), 0);
    check("b_queue_drained", exp_b.size(), 0);
    finish_run();
  end

endmodule
`default_nettype wire
